rob_param: RTL and testbench
============================

Name: rob_param

Overview:
- Parametrised circular reorder buffer for the out-of-order RV32I core, between decoder/issue and regfile/pc.
- Allocates tags in program order, accepts results from NUM_WB writeback channels and commits one entry per cycle in order to the regfile.
- Resolves branch mispredictions at commit: redirects pc and flushes every entry.
- Exposes operand lookup so the decoder can read completed-but-uncommitted results.

Parameters:
- TAG_W, 4, tag width; ROB_DEPTH = 2**TAG_W (power of two by construction).
- DATA_W, 32, result width.
- ADDR_W, 32, pc/target width.
- REG_W, 5, architectural register index width.
- NUM_WB, 2, writeback channels (1..4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; sampled at posedge clk, state cleared when 0.
- rdy  in  1  global enable; when 0, all state holds and pulse outputs are 0.
- if_idle  out  1  free entry available (count != ROB_DEPTH); combinational.
- alloc_valid  in  1  decoder allocation request.
- alloc_rd  in  REG_W  destination register.
- alloc_is_branch  in  1  entry may redirect.
- tag_to_decoder  out  TAG_W  tag of the slot being allocated (= tail); combinational.
- query_tag1 / query_tag2  in  TAG_W  operand lookup tags.
- query_ready1 / query_ready2  out  1  entry busy and result present; combinational.
- query_data1 / query_data2  out  DATA_W  entry result; 0 when not ready.
- wb_valid  in  NUM_WB  per-channel writeback strobe.
- wb_tag  in  NUM_WB*TAG_W  packed, channel i at [i*TAG_W +: TAG_W].
- wb_data  in  NUM_WB*DATA_W  packed results.
- wb_mispredict  in  NUM_WB  branch resolved wrongly.
- wb_target  in  NUM_WB*ADDR_W  correct pc for a mispredicted branch.
- if_commit  out  1  registered one-cycle commit pulse.
- pos_commit  out  REG_W  committed rd.
- data_commit  out  DATA_W  committed value.
- tag_commit  out  TAG_W  committed tag; the regfile clears its rename when it matches.
- if_jump  out  1  registered one-cycle redirect pulse.
- pc_to_jump  out  ADDR_W  redirect target.

Behaviour:
- State:
  - Per entry: busy, ready, is_branch, mispredict, rd, data, target.
  - head and tail pointers, TAG_W bits each, wrapping modulo ROB_DEPTH.
  - count, TAG_W+1 bits.
- Reset (rst=0 at posedge): all busy/ready=0, head=tail=count=0; if_commit=if_jump=0, pos_commit=data_commit=tag_commit=pc_to_jump=0.
- Allocation fires when alloc_valid & if_idle & rdy:
  - entry[tail] gets busy=1, ready=0, rd, is_branch; tail+1.
  - if_idle uses the current-cycle count; a slot freed by a same-cycle commit is not reusable until next cycle.
- Writeback, channel i, when wb_valid[i] & rdy and entry busy:
  - sets ready=1, data, mispredict (masked by is_branch), target.
  - Writeback to a non-busy entry is ignored, including a slot allocated in the same cycle.
  - Two channels with the same tag in one cycle: the lowest channel index wins.
- Commit: when entry[head] has busy & ready (registered state) and rdy:
  - next cycle if_commit=1, pos_commit=rd, data_commit=data, tag_commit=head.
  - entry busy=0; head+1.
  - Minimum latency writeback→commit pulse is 2 cycles.
  - rd=0 still commits; the regfile ignores x0.
- Count: +1 on allocation, -1 on commit; both in one cycle leaves it unchanged.
- Mispredict commit (head entry has mispredict=1), in addition to the normal commit pulse:
  - if_jump=1 and pc_to_jump=target, registered.
  - All entries cleared; head=tail=count=0.
  - An allocation and any writebacks in that cycle are discarded.
  - The decoder refetches only after if_jump.
- Non-commit cycles: if_commit and if_jump return to 0; pos/data/tag/pc hold their last values.
- Full (count=ROB_DEPTH): if_idle=0, alloc_valid ignored.
- Empty: no commit; query outputs report not-ready.
- Reset mid-operation overrides allocation, writeback and commit in the same cycle.

Optional Feature:
- ROB_BYPASS_EN:
  - When defined, query_readyN/query_dataN also forward a same-cycle valid writeback whose tag matches queryN, lowest channel first.
  - When undefined, lookup sees registered entry state only; a result becomes visible the cycle after writeback.

Test Plan:
- Reset, then fill: 16 allocations → tags 0..15 in order; if_idle=0 after the 16th; a 17th alloc_valid is ignored.
- Out-of-order writeback: tags 0,1,2 allocated; wb tag2=0x33, then tag0=0x11, then tag1=0x22 → commits in order 0x11, 0x22, 0x33 with tag_commit 0,1,2, one per cycle.
- Dual-channel collision: wb_valid=2'b11, both tag 5, data 0xA/0xB → entry 5 commits 0xA.
- Mispredict flush: tags 0..3 allocated; tag1 branch written with mispredict=1, target 0x100 → tag0 commits, then tag1 commits with if_jump=1, pc_to_jump=0x100; next cycle count=0 and the next allocation gets tag 0.
- Wrap-around: 20 alloc/commit pairs → tags wrap 15→0; no lost or duplicated commits.
- Lookup: wb tag3=0xDEAD at cycle N → query_ready=1 at N+1 without ROB_BYPASS_EN, at N with it; rdy=0 for 3 cycles freezes all state and pulses.

Source files
------------

// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
//  Module      : rob_param
//  Description : Parametrised circular reorder buffer. Allocates tags in
//                program order, accepts results from NUM_WB writeback
//                channels, commits one entry per cycle in order and flushes
//                the whole buffer when a mispredicted branch commits.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional build macro:
//    ROB_BYPASS_EN  - operand lookup also forwards same-cycle writebacks.
// ----------------------------------------------------------------------------
//  Ports:
//    clk, rst (sync, active-low), rdy (global enable)
//    if_idle, tag_to_decoder            : allocation status / next tag
//    alloc_valid, alloc_rd, alloc_is_branch : allocation request
//    query_tag1/2 -> query_ready1/2, query_data1/2 : operand lookup
//    wb_valid, wb_tag, wb_data, wb_mispredict, wb_target : packed writeback
//    if_commit, pos_commit, data_commit, tag_commit : registered commit
//    if_jump, pc_to_jump                : registered redirect
// ============================================================================
module rob_param #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int NUM_WB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    output logic                     if_idle,
    input  logic                     alloc_valid,
    input  logic [REG_W-1:0]         alloc_rd,
    input  logic                     alloc_is_branch,
    output logic [TAG_W-1:0]         tag_to_decoder,
    input  logic [TAG_W-1:0]         query_tag1,
    input  logic [TAG_W-1:0]         query_tag2,
    output logic                     query_ready1,
    output logic                     query_ready2,
    output logic [DATA_W-1:0]        query_data1,
    output logic [DATA_W-1:0]        query_data2,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    input  logic [NUM_WB-1:0]        wb_mispredict,
    input  logic [NUM_WB*ADDR_W-1:0] wb_target,
    output logic                     if_commit,
    output logic [REG_W-1:0]         pos_commit,
    output logic [DATA_W-1:0]        data_commit,
    output logic [TAG_W-1:0]         tag_commit,
    output logic                     if_jump,
    output logic [ADDR_W-1:0]        pc_to_jump
);

    localparam int ROB_DEPTH = 1 << TAG_W;
    localparam logic [TAG_W:0] C_FULL = (TAG_W+1)'(ROB_DEPTH);

    // Per-entry state
    logic [ROB_DEPTH-1:0] busy_q,  busy_d;
    logic [ROB_DEPTH-1:0] ready_q, ready_d;
    logic [ROB_DEPTH-1:0] br_q,    br_d;
    logic [ROB_DEPTH-1:0] mp_q,    mp_d;
    logic [REG_W-1:0]     rd_q   [ROB_DEPTH];
    logic [REG_W-1:0]     rd_d   [ROB_DEPTH];
    logic [DATA_W-1:0]    data_q [ROB_DEPTH];
    logic [DATA_W-1:0]    data_d [ROB_DEPTH];
    logic [ADDR_W-1:0]    tgt_q  [ROB_DEPTH];
    logic [ADDR_W-1:0]    tgt_d  [ROB_DEPTH];

    logic [TAG_W-1:0] head_q,  head_d;
    logic [TAG_W-1:0] tail_q,  tail_d;
    logic [TAG_W:0]   count_q, count_d;

    // Registered commit / redirect outputs
    logic              commit_q, commit_d;
    logic              jump_q,   jump_d;
    logic [REG_W-1:0]  pos_q,    pos_d;
    logic [DATA_W-1:0] cdata_q,  cdata_d;
    logic [TAG_W-1:0]  ctag_q,   ctag_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;

    // Writeback decode per entry (lowest channel index wins)
    logic [ROB_DEPTH-1:0] wb_hit;
    logic [ROB_DEPTH-1:0] wb_msel;
    logic [DATA_W-1:0]    wb_dsel [ROB_DEPTH];
    logic [ADDR_W-1:0]    wb_tsel [ROB_DEPTH];

    logic do_alloc;
    logic do_commit;
    logic do_flush;

    assign if_idle        = (count_q != C_FULL);
    assign tag_to_decoder = tail_q;
    assign do_alloc       = alloc_valid & if_idle & rdy;
    assign do_commit      = rdy & busy_q[head_q] & ready_q[head_q];
    assign do_flush       = do_commit & mp_q[head_q];

    always_comb begin
        for (int e = 0; e < ROB_DEPTH; e++) begin
            wb_hit[e]  = 1'b0;
            wb_msel[e] = 1'b0;
            wb_dsel[e] = '0;
            wb_tsel[e] = '0;
            // Scan high to low so the lowest matching channel is applied last.
            for (int c = NUM_WB - 1; c >= 0; c--) begin
                if (wb_valid[c] && (wb_tag[c*TAG_W +: TAG_W] == TAG_W'(e))) begin
                    wb_hit[e]  = 1'b1;
                    wb_msel[e] = wb_mispredict[c];
                    wb_dsel[e] = wb_data[c*DATA_W +: DATA_W];
                    wb_tsel[e] = wb_target[c*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Operand lookup
    always_comb begin
        query_ready1 = busy_q[query_tag1] & ready_q[query_tag1];
        query_data1  = query_ready1 ? data_q[query_tag1] : '0;
        query_ready2 = busy_q[query_tag2] & ready_q[query_tag2];
        query_data2  = query_ready2 ? data_q[query_tag2] : '0;
`ifdef ROB_BYPASS_EN
        if (!query_ready1 && rdy && busy_q[query_tag1] && wb_hit[query_tag1]) begin
            query_ready1 = 1'b1;
            query_data1  = wb_dsel[query_tag1];
        end
        if (!query_ready2 && rdy && busy_q[query_tag2] && wb_hit[query_tag2]) begin
            query_ready2 = 1'b1;
            query_data2  = wb_dsel[query_tag2];
        end
`endif
    end

    // Next-state
    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        br_d    = br_q;
        mp_d    = mp_q;
        rd_d    = rd_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Pulses drop on every non-commit cycle, including rdy=0 cycles.
        commit_d = do_commit;
        jump_d   = do_flush;
        pos_d    = do_commit ? rd_q[head_q]   : pos_q;
        cdata_d  = do_commit ? data_q[head_q] : cdata_q;
        ctag_d   = do_commit ? head_q         : ctag_q;
        pc_d     = do_flush  ? tgt_q[head_q]  : pc_q;

        if (do_flush) begin
            // Allocation and writebacks in the flush cycle are discarded.
            busy_d  = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (rdy) begin
            for (int e = 0; e < ROB_DEPTH; e++) begin
                if (wb_hit[e] && busy_q[e]) begin
                    ready_d[e] = 1'b1;
                    data_d[e]  = wb_dsel[e];
                    mp_d[e]    = wb_msel[e] & br_q[e];
                    tgt_d[e]   = wb_tsel[e];
                end
            end
            if (do_commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + 1'b1;
            end
            // Tail slot is never busy here: allocation requires count < depth.
            if (do_alloc) begin
                busy_d[tail_q]  = 1'b1;
                ready_d[tail_q] = 1'b0;
                mp_d[tail_q]    = 1'b0;
                br_d[tail_q]    = alloc_is_branch;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= '0;
            ready_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            commit_q <= 1'b0;
            jump_q   <= 1'b0;
            pos_q    <= '0;
            cdata_q  <= '0;
            ctag_q   <= '0;
            pc_q     <= '0;
        end else begin
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            commit_q <= commit_d;
            jump_q   <= jump_d;
            pos_q    <= pos_d;
            cdata_q  <= cdata_d;
            ctag_q   <= ctag_d;
            pc_q     <= pc_d;
        end
    end

    // Payload storage; only meaningful while busy/ready, so no reset needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_q   <= br_d;
            mp_q   <= mp_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            tgt_q  <= tgt_d;
        end
    end

    assign if_commit   = commit_q;
    assign if_jump     = jump_q;
    assign pos_commit  = pos_q;
    assign data_commit = cdata_q;
    assign tag_commit  = ctag_q;
    assign pc_to_jump  = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_rob_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rob_param
//  Description : Self-checking bench for rob_param. A queue-based program
//                order model predicts every output each cycle; directed
//                scenarios are followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_param;

    localparam int TW = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int NW = 2;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst, rdy;
    logic            if_idle;
    logic            alloc_valid, alloc_is_branch;
    logic [RW-1:0]   alloc_rd;
    logic [TW-1:0]   tag_to_decoder;
    logic [TW-1:0]   query_tag1, query_tag2;
    logic            query_ready1, query_ready2;
    logic [DW-1:0]   query_data1, query_data2;
    logic [NW-1:0]   wb_valid, wb_mispredict;
    logic [NW*TW-1:0] wb_tag;
    logic [NW*DW-1:0] wb_data;
    logic [NW*AW-1:0] wb_target;
    logic            if_commit, if_jump;
    logic [RW-1:0]   pos_commit;
    logic [DW-1:0]   data_commit;
    logic [TW-1:0]   tag_commit;
    logic [AW-1:0]   pc_to_jump;

    rob_param #(.TAG_W(TW), .DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .NUM_WB(NW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .if_idle(if_idle),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .tag_to_decoder(tag_to_decoder),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_data1(query_data1), .query_data2(query_data2),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
        .tag_commit(tag_commit), .if_jump(if_jump), .pc_to_jump(pc_to_jump)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: in-flight tags in program order plus per-tag payload.
    logic [TW-1:0] order[$];
    logic [TW-1:0] nt;
    logic [RW-1:0] m_rd   [DEPTH];
    logic [DW-1:0] m_data [DEPTH];
    logic [AW-1:0] m_tgt  [DEPTH];
    bit            m_br   [DEPTH];
    bit            m_rdy  [DEPTH];
    bit            m_mp   [DEPTH];
    bit            e_commit, e_jump;
    logic [RW-1:0] e_pos;
    logic [DW-1:0] e_data;
    logic [TW-1:0] e_tag;
    logic [AW-1:0] e_pc;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit inq(input logic [TW-1:0] t);
        foreach (order[i]) if (order[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update();
        bit cm, fl;
        int presz;
        logic [TW-1:0] t;
        if (!rst) begin
            order.delete();
            nt = '0;
            e_commit = 0; e_jump = 0;
            e_pos = '0; e_data = '0; e_tag = '0; e_pc = '0;
        end else if (!rdy) begin
            e_commit = 0; e_jump = 0;
        end else begin
            cm = (order.size() > 0) && m_rdy[order[0]];
            fl = cm && m_mp[order[0]];
            e_commit = cm;
            e_jump   = fl;
            if (cm) begin
                e_pos  = m_rd[order[0]];
                e_data = m_data[order[0]];
                e_tag  = order[0];
                if (fl) e_pc = m_tgt[order[0]];
            end
            if (fl) begin
                order.delete();
                nt = '0;
            end else begin
                presz = order.size();
                for (int c = NW - 1; c >= 0; c--) begin
                    t = wb_tag[c*TW +: TW];
                    if (wb_valid[c] && inq(t)) begin
                        m_rdy[t]  = 1;
                        m_data[t] = wb_data[c*DW +: DW];
                        m_mp[t]   = wb_mispredict[c] && m_br[t];
                        m_tgt[t]  = wb_target[c*AW +: AW];
                    end
                end
                if (cm) void'(order.pop_front());
                if (alloc_valid && presz < DEPTH) begin
                    m_rd[nt] = alloc_rd; m_br[nt] = alloc_is_branch;
                    m_rdy[nt] = 0; m_mp[nt] = 0;
                    order.push_back(nt);
                    nt = nt + 1'b1;
                end
            end
        end
    endtask

    task automatic exp_query(input logic [TW-1:0] q, output bit r, output logic [DW-1:0] d);
        r = inq(q) && m_rdy[q];
        d = r ? m_data[q] : '0;
`ifdef ROB_BYPASS_EN
        if (!r && rdy && inq(q)) begin
            for (int c = NW - 1; c >= 0; c--) begin
                if (wb_valid[c] && wb_tag[c*TW +: TW] == q) begin
                    r = 1; d = wb_data[c*DW +: DW];
                end
            end
        end
`endif
    endtask

    task automatic check_comb();
        bit r; logic [DW-1:0] d;
        chk("if_idle", if_idle, order.size() != DEPTH);
        chk("tag_to_decoder", tag_to_decoder, nt);
        exp_query(query_tag1, r, d);
        chk("query_ready1", query_ready1, r);
        chk("query_data1", query_data1, d);
        exp_query(query_tag2, r, d);
        chk("query_ready2", query_ready2, r);
        chk("query_data2", query_data2, d);
    endtask

    task automatic check_reg();
        chk("if_commit", if_commit, e_commit);
        chk("if_jump", if_jump, e_jump);
        chk("pos_commit", pos_commit, e_pos);
        chk("data_commit", data_commit, e_data);
        chk("tag_commit", tag_commit, e_tag);
        chk("pc_to_jump", pc_to_jump, e_pc);
    endtask

    task automatic cyc();
        #1;
        check_comb();
        @(posedge clk);
        model_update();
        #1;
        check_reg();
    endtask

    task automatic clr_in();
        alloc_valid = 0; alloc_is_branch = 0; alloc_rd = '0;
        wb_valid = '0; wb_mispredict = '0;
    endtask

    task automatic setwb(input int ch, input logic [TW-1:0] t, input logic [DW-1:0] d,
                         input bit mp, input logic [AW-1:0] tg);
        wb_valid[ch] = 1'b1;
        wb_tag[ch*TW +: TW] = t;
        wb_data[ch*DW +: DW] = d;
        wb_mispredict[ch] = mp;
        wb_target[ch*AW +: AW] = tg;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 0;
        cyc();
        rst = 1;
    endtask

    task automatic drain(input int n);
        clr_in();
        for (int i = 0; i < n; i++) cyc();
    endtask

    int ncommit;

    initial begin
        rst = 0; rdy = 1;
        query_tag1 = '0; query_tag2 = '0;
        wb_tag = '0; wb_data = '0; wb_target = '0;
        clr_in();
        // First reset edge without checks: state is unknown before it.
        @(posedge clk); model_update(); #1;
        do_reset();
        chk("reset_idle", if_idle, 1);
        chk("reset_commit", if_commit, 0);

        // Fill: tags 0..15 in order, then a 17th request is ignored.
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1; alloc_rd = RW'(i);
            chk("fill_tag", tag_to_decoder, i);
            cyc();
        end
        chk("full_idle", if_idle, 0);
        cyc();
        chk("full_tail", tag_to_decoder, 0);
        do_reset();

        // Out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) begin alloc_valid = 1; alloc_rd = RW'(i + 1); cyc(); end
        clr_in(); setwb(0, 2, 32'h33, 0, 0); cyc();
        clr_in(); setwb(1, 0, 32'h11, 0, 0); cyc();
        clr_in(); setwb(0, 1, 32'h22, 0, 0); cyc();
        drain(4);
        do_reset();

        // Dual-channel collision on tag 5.
        for (int i = 0; i < 6; i++) begin alloc_valid = 1; alloc_rd = RW'(i); cyc(); end
        for (int i = 0; i < 5; i++) begin clr_in(); setwb(0, TW'(i), DW'(i + 100), 0, 0); cyc(); end
        clr_in(); setwb(0, 5, 32'hA, 0, 0); setwb(1, 5, 32'hB, 0, 0); cyc();
        drain(4);
        do_reset();

        // Mispredict flush.
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1; alloc_rd = RW'(i + 8); alloc_is_branch = (i == 1); cyc();
        end
        clr_in(); setwb(0, 0, 32'h5, 0, 0); setwb(1, 3, 32'h7, 0, 0); cyc();
        clr_in(); setwb(1, 1, 32'h9, 1, 32'h100); cyc();
        clr_in();
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (if_jump === 1'b1) break;
        end
        chk("jump_seen", if_jump, 1);
        chk("jump_pc", pc_to_jump, 32'h100);
        chk("jump_tag", tag_commit, 1);
        chk("flush_tail", tag_to_decoder, 0);
        chk("flush_idle", if_idle, 1);
        alloc_valid = 1; alloc_rd = 3; cyc();
        drain(2);
        do_reset();

        // Wrap-around: 20 alloc/commit pairs.
        ncommit = 0;
        for (int i = 0; i <= 20; i++) begin
            clr_in();
            if (i < 20) begin alloc_valid = 1; alloc_rd = RW'(i); end
            if (i >= 1) setwb(0, TW'((i - 1) % DEPTH), DW'(i * 7), 0, 0);
            cyc();
            if (if_commit === 1'b1) ncommit++;
        end
        for (int i = 0; i < 4; i++) begin
            clr_in(); cyc();
            if (if_commit === 1'b1) ncommit++;
        end
        chk("wrap_commits", ncommit, 20);
        do_reset();

        // Lookup and rdy freeze.
        for (int i = 0; i < 4; i++) begin alloc_valid = 1; alloc_rd = RW'(i); cyc(); end
        clr_in(); query_tag1 = 3; query_tag2 = 0;
        setwb(0, 3, 32'hDEAD, 0, 0); cyc();
        clr_in(); #1;
        chk("lookup_ready", query_ready1, 1);
        chk("lookup_data", query_data1, 32'hDEAD);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1; setwb(0, 0, 32'h1, 0, 0); cyc();
        end
        chk("freeze_tail", tag_to_decoder, 4);
        rdy = 1; clr_in();
        for (int i = 0; i < 3; i++) begin clr_in(); setwb(1, TW'(i), DW'(i + 50), 0, 0); cyc(); end
        drain(4);

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            clr_in();
            rst = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            alloc_valid = $urandom_range(0, 1);
            alloc_rd = RW'($urandom);
            alloc_is_branch = ($urandom_range(0, 3) == 0);
            query_tag1 = TW'($urandom); query_tag2 = TW'($urandom);
            for (int c = 0; c < NW; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    logic [TW-1:0] t;
                    if (order.size() > 0 && $urandom_range(0, 4) != 0)
                        t = order[$urandom_range(0, order.size() - 1)];
                    else
                        t = TW'($urandom);
                    setwb(c, t, $urandom, ($urandom_range(0, 7) == 0), $urandom);
                end
            end
            cyc();
        end
        rst = 1; rdy = 1;
        drain(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
